// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 demux and its buffered lane stage: default sizes, lane select codes, clog2.
package demux_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_lane_fifo2_if.sv
// Handshake bundle for demux_lane_fifo2: one upstream push port and two independent lane drain ports.
interface demux_lane_fifo2_if #(
  parameter int WIDTH = demux_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic             in_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;

  modport master (
    output in_valid, in_sel, data_in0, data_in1, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_sel, data_in0, data_in1, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );
endinterface

// File: rtl/demux_lane_sfifo.sv
// Single-lane show-ahead FIFO: push lands at the edge, head visible 1 cycle later; data reads 0 when empty.
// Caller must not push while full; pop while empty is ignored. occ port exists only with DEMUX_FIFO_STATUS_EN.
module demux_lane_sfifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_FIFO_STATUS_EN
  ,
  output logic [clog2(DEPTH):0] occ
`endif
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign data    = valid ? mem[rd_ptr[AW-1:0]] : '0;

`ifdef DEMUX_FIFO_STATUS_EN
  assign occ = wr_ptr - rd_ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/demux_lane_fifo2.sv
// Routes the demux lane outputs into two independent show-ahead FIFOs; 1-cycle push-to-valid latency.
// in_ready is !full of the lane named by in_sel; each consumer backpressures its own lane. DEMUX_FIFO_STATUS_EN adds occ0/occ1/ovf_attempt.
module demux_lane_fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_lane_fifo2_if.slave     bus
`ifdef DEMUX_FIFO_STATUS_EN
  ,
  output logic [clog2(DEPTH):0] occ0,
  output logic [clog2(DEPTH):0] occ1,
  output logic                  ovf_attempt
`endif
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  assign bus.in_ready = (bus.in_sel == LANE1) ? !full1 : !full0;
  assign push0 = bus.in_valid && bus.in_ready && (bus.in_sel == LANE0);
  assign push1 = bus.in_valid && bus.in_ready && (bus.in_sel == LANE1);

  demux_lane_sfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (bus.data_in0),
    .full      (full0),
    .pop       (bus.out0_ready),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data)
`ifdef DEMUX_FIFO_STATUS_EN
    ,
    .occ       (occ0)
`endif
  );

  demux_lane_sfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (bus.data_in1),
    .full      (full1),
    .pop       (bus.out1_ready),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data)
`ifdef DEMUX_FIFO_STATUS_EN
    ,
    .occ       (occ1)
`endif
  );

`ifdef DEMUX_FIFO_STATUS_EN
  // Sticky record of any rejected upstream word; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_attempt <= 1'b0;
    else if (bus.in_valid && !bus.in_ready) ovf_attempt <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_demux_lane_fifo2.sv
// Randomised + directed bench for demux_lane_fifo2 against a queue-based lane model.
module tb_demux_lane_fifo2;
  import demux_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             ovf_exp;

  demux_lane_fifo2_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_FIFO_STATUS_EN
  logic [clog2(DEPTH):0] occ0;
  logic [clog2(DEPTH):0] occ1;
  logic                  ovf_attempt;
`endif

  demux_lane_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef DEMUX_FIFO_STATUS_EN
    ,
    .occ0        (occ0),
    .occ1        (occ1),
    .ovf_attempt (ovf_attempt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic sel);
    logic [WIDTH-1:0] h0;
    logic [WIDTH-1:0] h1;
    int               sz;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    sz = sel ? q1.size() : q0.size();
    chk("in_ready",   {31'd0, bus.in_ready},   {31'd0, sz < DEPTH});
    chk("out0_valid", {31'd0, bus.out0_valid}, {31'd0, q0.size() > 0});
    chk("out0_data",  {28'd0, bus.out0_data},  {28'd0, h0});
    chk("out1_valid", {31'd0, bus.out1_valid}, {31'd0, q1.size() > 0});
    chk("out1_data",  {28'd0, bus.out1_data},  {28'd0, h1});
`ifdef DEMUX_FIFO_STATUS_EN
    chk("occ0", 32'(occ0), 32'(q0.size()));
    chk("occ1", 32'(occ1), 32'(q1.size()));
    chk("ovf_attempt", {31'd0, ovf_attempt}, {31'd0, ovf_exp});
`endif
  endtask

  // One cycle: drive after negedge, check combinational view, then advance the model at posedge.
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic r0, input logic r1);
    logic pop0, pop1, acc;
    @(negedge clk);
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.data_in0   = a;
    bus.data_in1   = b;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
    check_outputs(s);
    pop0 = r0 && (q0.size() > 0);
    pop1 = r1 && (q1.size() > 0);
    acc  = v && ((s ? q1.size() : q0.size()) < DEPTH);
    @(posedge clk);
    if (v && !acc) ovf_exp = 1'b1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(b);
      else   q0.push_back(a);
    end
  endtask

  task automatic idle(input logic s);
    step(1'b0, s, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ovf_exp = 1'b0;
    bus.in_valid = 1'b0; bus.in_sel = 1'b0;
    bus.data_in0 = '0;   bus.data_in1 = '0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    rst_n = 1'b0;

    // 1: reset values, both selects
    #12;
    check_outputs(1'b0);
    bus.in_sel = 1'b1; #1;
    check_outputs(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    idle(1'b1);

    // 2: one word per lane, visible a cycle later
    step(1'b1, 1'b0, 4'd1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd3, 4'd9, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    idle(1'b1);

    // 3: fill lane 0, check backpressure only on lane 0, drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 4'(i), 4'hf, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    step(1'b1, 1'b1, 4'h0, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    idle(1'b0);

    // 4: full lane 0 with push and pop together: pop only
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'(8 + i), 4'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd7, 4'h0, 1'b1, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);

    // 5: lane 1 at 2 entries, push+pop across pointer wrap
    idle(1'b1);
    step(1'b1, 1'b1, 4'h0, 4'd10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 4'd11, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h0, 4'(12 + i), 1'b0, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
    idle(1'b1);

    // 6: asynchronous reset with 3 words queued on lane 0
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(2 + i), 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q0.delete(); q1.delete(); ovf_exp = 1'b0;
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
    step(1'b1, 1'b0, 4'd13, 4'h0, 1'b0, 1'b0);
    idle(1'b0);

    // Random traffic with varying consumer pressure
    for (int i = 0; i < 400; i++) begin
      logic v, s, r0, r1;
      int   bias;
      bias = (i < 200) ? 30 : 75;
      v  = ($urandom_range(99) < 70);
      s  = $urandom_range(1);
      r0 = ($urandom_range(99) < bias);
      r1 = ($urandom_range(99) < (100 - bias));
      step(v, s, 4'($urandom), 4'($urandom), r0, r1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
